branchpredict_satcnt: RTL and testbench

//  Parametrised saturating-counter branch predictor; successor to the 1-bit last-outcome table.

---
 rtl/branchpredict_satcnt_if.sv | 25 ++
 rtl/branchpredict_satcnt.sv | 154 +++++++++++++++
 tb/tb_branchpredict_satcnt.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/branchpredict_satcnt_if.sv
// Predictor request/training bundle between fetch/execute and the
// saturating-counter branch predictor.
interface branchpredict_satcnt_if #(
    parameter int PCWIDTH = 32
);
    logic               predict;
    logic [PCWIDTH-1:0] pc_predict;
    logic               prediction;
    logic               result_rdy;
    logic [PCWIDTH-1:0] pc_result;
    logic               result;
    logic               ready;

    modport master (
        output predict, pc_predict,
        output result_rdy, pc_result, result,
        input  prediction, ready
    );

    modport slave (
        input  predict, pc_predict,
        input  result_rdy, pc_result, result,
        output prediction, ready
    );
endinterface

// File: rtl/branchpredict_satcnt.sv
// Saturating-counter branch predictor, bimodal or gshare indexed,
// with an init sweep and a forwarded 2-stage training pipeline.
module branchpredict_satcnt #(
    parameter int PCWIDTH        = 32,
    parameter int LOG2TABLEDEPTH = 12,
    parameter int TABLEDEPTH     = 2 ** LOG2TABLEDEPTH,
    parameter int CNTWIDTH       = 2,
    parameter int HISTWIDTH      = 0,
    parameter int INITCOUNT      = 1
) (
    input logic                   clk,
    input logic                   resetn,
    branchpredict_satcnt_if.slave bp
);
    localparam int L = LOG2TABLEDEPTH;
    localparam int C = CNTWIDTH;
    localparam logic [C-1:0] CMAX = {C{1'b1}};

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t         state;
    logic           run;
    logic [L-1:0]   init_idx;
    logic           ready_q;
    logic           pred_q;

    logic [C-1:0]   mem [TABLEDEPTH];

    logic [L-1:0]   ghr_ext;
    logic [L-1:0]   pred_idx;
    logic [L-1:0]   upd_idx;
    logic [C-1:0]   pred_cnt;
    logic [C-1:0]   upd_cnt;
    logic [C-1:0]   upd_next;

    logic           u2_valid;
    logic [L-1:0]   u2_idx;
    logic [C-1:0]   u2_cnt;

    logic           we;
    logic [L-1:0]   waddr;
    logic [C-1:0]   wdata;

    logic           unused_pc;

    assign run       = (state == S_RUN);
    assign unused_pc = ^{bp.pc_predict, bp.pc_result};

    generate
        if (HISTWIDTH == 0) begin : g_bimodal
            assign ghr_ext = '0;
        end else begin : g_gshare
            logic [HISTWIDTH-1:0] ghr;
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    ghr <= '0;
                end else if (run && bp.result_rdy) begin
                    ghr <= (ghr << 1) | HISTWIDTH'(bp.result);
                end
            end
            assign ghr_ext = L'(ghr);
        end
    endgenerate

    assign pred_idx = bp.pc_predict[L+1:2] ^ ghr_ext;
    assign upd_idx  = bp.pc_result[L+1:2] ^ ghr_ext;

    // Reads bypass the array when the entry is being written this cycle.
    always_comb begin
        pred_cnt = mem[pred_idx];
        if (u2_valid && (u2_idx == pred_idx)) begin
            pred_cnt = u2_cnt;
        end
        upd_cnt = mem[upd_idx];
        if (u2_valid && (u2_idx == upd_idx)) begin
            upd_cnt = u2_cnt;
        end
    end

    always_comb begin
        upd_next = upd_cnt;
        if (bp.result) begin
            if (upd_cnt != CMAX) begin
                upd_next = upd_cnt + C'(1);
            end
        end else begin
            if (upd_cnt != '0) begin
                upd_next = upd_cnt - C'(1);
            end
        end
    end

    always_comb begin
        we    = 1'b0;
        waddr = '0;
        wdata = '0;
        unique case (1'b1)
            !run: begin
                we    = 1'b1;
                waddr = init_idx;
                wdata = C'(INITCOUNT);
            end
            (run && u2_valid): begin
                we    = 1'b1;
                waddr = u2_idx;
                wdata = u2_cnt;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_INIT;
            init_idx <= '0;
            ready_q  <= 1'b0;
            pred_q   <= 1'b0;
            u2_valid <= 1'b0;
            u2_idx   <= '0;
            u2_cnt   <= '0;
        end else begin
            case (state)
                S_INIT: begin
                    init_idx <= init_idx + L'(1);
                    if (init_idx == L'(TABLEDEPTH - 1)) begin
                        state   <= S_RUN;
                        ready_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    state <= S_RUN;
                end
                default: state <= S_INIT;
            endcase
            if (run && bp.predict) begin
                pred_q <= pred_cnt[C-1];
            end
            u2_valid <= run && bp.result_rdy;
            if (run && bp.result_rdy) begin
                u2_idx <= upd_idx;
                u2_cnt <= upd_next;
            end
        end
    end

    assign bp.prediction = pred_q;
    assign bp.ready      = ready_q;
endmodule

// File: tb/tb_branchpredict_satcnt.sv
// Scoreboard bench: bimodal instance u0 and gshare (HISTWIDTH=4) instance u1.
module tb_branchpredict_satcnt;
    bit   clk;
    logic resetn;

    int n_cmp = 0;
    int n_err = 0;

    bit q0[$];
    bit q1[$];
    bit pv0, pv1;

    branchpredict_satcnt_if #(.PCWIDTH(32)) bp0 ();
    branchpredict_satcnt_if #(.PCWIDTH(32)) bp1 ();

    branchpredict_satcnt u0 (
        .clk    (clk),
        .resetn (resetn),
        .bp     (bp0.slave)
    );

    branchpredict_satcnt #(.HISTWIDTH(4)) u1 (
        .clk    (clk),
        .resetn (resetn),
        .bp     (bp1.slave)
    );

    always #5 clk = ~clk;

    task automatic check(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: a prediction is presented the cycle after a request.
    always @(posedge clk) begin
        pv0 <= bp0.predict;
        pv1 <= bp1.predict;
    end

    always @(negedge clk) begin
        if (pv0) begin
            n_cmp++;
            if (q0.size() == 0) begin
                n_err++;
                $display("FAIL pred0: output with empty queue");
            end else begin
                bit e;
                e = q0.pop_front();
                if (bp0.prediction !== e) begin
                    n_err++;
                    $display("FAIL pred0: got %b, expected %b",
                             bp0.prediction, e);
                end
            end
        end
        if (pv1) begin
            n_cmp++;
            if (q1.size() == 0) begin
                n_err++;
                $display("FAIL pred1: output with empty queue");
            end else begin
                bit e;
                e = q1.pop_front();
                if (bp1.prediction !== e) begin
                    n_err++;
                    $display("FAIL pred1: got %b, expected %b",
                             bp1.prediction, e);
                end
            end
        end
    end

    task automatic clr();
        bp0.predict = 0; bp0.pc_predict = '0;
        bp0.result_rdy = 0; bp0.pc_result = '0; bp0.result = 0;
        bp1.predict = 0; bp1.pc_predict = '0;
        bp1.result_rdy = 0; bp1.pc_result = '0; bp1.result = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic train0(logic [31:0] pc, bit r);
        step();
        bp0.result_rdy = 1; bp0.pc_result = pc; bp0.result = r;
    endtask

    task automatic train1(logic [31:0] pc, bit r);
        step();
        bp1.result_rdy = 1; bp1.pc_result = pc; bp1.result = r;
    endtask

    task automatic pred0(logic [31:0] pc, bit e);
        step();
        bp0.predict = 1; bp0.pc_predict = pc;
        q0.push_back(e);
    endtask

    task automatic pred1(logic [31:0] pc, bit e);
        step();
        bp1.predict = 1; bp1.pc_predict = pc;
        q1.push_back(e);
    endtask

    // Reset is released #1 after a posedge; count edges until ready.
    task automatic wait_ready(output int n);
        n = 0;
        while (n < 6000) begin
            @(posedge clk);
            n++;
            #1;
            if (bp0.ready) break;
        end
    endtask

    initial begin
        int n;
        clr();
        resetn = 0;
        #3;
        check("reset ready0", int'(bp0.ready), 0);
        check("reset pred0", int'(bp0.prediction), 0);
        check("reset ready1", int'(bp1.ready), 0);
        @(posedge clk);
        #1;
        resetn = 1;

        // T1: request during the sweep is ignored; ready after 4096
        pred0(32'h40, 0);
        step();
        check("init ready", int'(bp0.ready), 0);
        @(posedge clk);
        #1;
        resetn = 0;
        #1;
        resetn = 1;
        wait_ready(n);
        check("ready latency", n, 4096);
        check("ready1", int'(bp1.ready), 1);
        pred0(32'h40, 0);

        // T2: spaced training and saturation at 3
        train0(32'h40, 1); step(); pred0(32'h40, 1);
        for (int i = 0; i < 5; i++) begin
            train0(32'h40, 1); step();
        end
        train0(32'h40, 0); step(); pred0(32'h40, 1);
        train0(32'h40, 0); step(); pred0(32'h40, 0);

        // T3: back-to-back same-entry updates
        train0(32'h80, 1); train0(32'h80, 1);
        step(); pred0(32'h80, 1);
        train0(32'h80, 0); step(); pred0(32'h80, 1);
        train0(32'h80, 0); step(); pred0(32'h80, 0);

        // T4: predict sees the U2 write of the same cycle
        train0(32'h100, 1); pred0(32'h100, 1);

        // Predict alongside U1 sees the pre-update value
        step();
        bp0.result_rdy = 1; bp0.pc_result = 32'h200; bp0.result = 1;
        bp0.predict = 1; bp0.pc_predict = 32'h200;
        q0.push_back(0);
        pred0(32'h200, 1);

        // T5: gshare index uses the shifted history
        train1(32'h40, 1); step();
        pred1(32'h40, 0);
        pred1(32'h44, 1);
        step();
        step();

        // T6: reset mid-sweep restarts it and discards training
        resetn = 0;
        #1;
        check("rst pred0", int'(bp0.prediction), 1'b0);
        check("rst pred1", int'(bp1.prediction), 1'b0);
        @(posedge clk);
        #1;
        resetn = 1;
        repeat (1000) @(posedge clk);
        #2;
        resetn = 0;
        #1;
        check("mid ready", int'(bp0.ready), 0);
        check("mid pred", int'(bp0.prediction), 0);
        @(posedge clk);
        #1;
        resetn = 1;
        wait_ready(n);
        check("ready latency 2", n, 4096);
        pred0(32'h100, 0);
        pred0(32'h40, 0);
        pred1(32'h44, 0);
        step();
        step();
        step();

        check("queue0 drained", q0.size(), 0);
        check("queue1 drained", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
